// File: rtl/game_pkg.sv
// Shared definitions for the light-cycle arena: cell codes, grid geometry,
// arena FSM encoding and the row-major cell address helper.
package game_pkg;

    localparam int GRID_COLS  = 80;
    localparam int GRID_ROWS  = 60;
    localparam int CELL_SHIFT = 3;
    localparam int NUM_CELLS  = GRID_COLS * GRID_ROWS;
    localparam int ADDR_W     = 13;

    typedef logic [1:0] cell_t;

    localparam cell_t CELL_EMPTY = 2'd0;
    localparam cell_t CELL_P1    = 2'd1;
    localparam cell_t CELL_P2    = 2'd2;
    localparam cell_t CELL_WALL  = 2'd3;

    typedef enum logic [2:0] {
        ST_CLEAR = 3'd0,
        ST_IDLE  = 3'd1,
        ST_READ  = 3'd2,
        ST_WRITE = 3'd3,
        ST_RESP  = 3'd4
    } state_t;

    // row*80 + col without a multiplier; only valid for an 80-column grid
    function automatic logic [ADDR_W-1:0] cell_addr(input logic [5:0] row,
                                                   input logic [6:0] col);
        logic [ADDR_W-1:0] r;
        r = {7'd0, row};
        return (r << 6) + (r << 4) + {6'd0, col};
    endfunction

endpackage

// File: rtl/grade_ram.sv
// Simple dual-port cell store: port A read/write for the arena FSM,
// port B read-only for the pixel path, both with registered read data.
module grade_ram #(
    parameter int DEPTH = 4800,
    parameter int AW    = 13,
    parameter int DW    = 2
) (
    input  logic          clk,
    input  logic [AW-1:0] a_addr,
    input  logic          a_we,
    input  logic [DW-1:0] a_wdata,
    output logic [DW-1:0] a_rdata,
    input  logic [AW-1:0] b_addr,
    output logic [DW-1:0] b_rdata
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (a_we) begin
            mem[a_addr] <= a_wdata;
        end
        a_rdata <= mem[a_addr];
        b_rdata <= mem[b_addr];
    end

endmodule

// File: rtl/grade_arena.sv
// Arena grid controller: clear sweep with wall frame, one-at-a-time move
// collision check plus trail marking, and a 1-cycle-latency pixel lookup.
module grade_arena
    import game_pkg::*;
#(
    parameter int COLS       = GRID_COLS,
    parameter int ROWS       = GRID_ROWS,
    parameter int CELL_SHIFT = game_pkg::CELL_SHIFT,
    parameter int BORDER     = 2
) (
    input  logic       CLOCK_50,
    input  logic       reset_n,
    input  logic       clear_req,
    output logic       clear_busy,
    input  logic       mv_valid,
    output logic       mv_ready,
    input  logic       mv_player,
    input  logic [6:0] mv_cur_col,
    input  logic [5:0] mv_cur_row,
    input  logic [6:0] mv_nxt_col,
    input  logic [5:0] mv_nxt_row,
    output logic       res_valid,
    output logic       res_hit,
    output logic [1:0] res_code,
    input  logic [9:0] next_x,
    input  logic [9:0] next_y,
    output logic [1:0] pix_cell
);

    localparam logic [6:0]        COL_LIM   = 7'(COLS);
    localparam logic [5:0]        ROW_LIM   = 6'(ROWS);
    localparam logic [6:0]        COL_LO    = 7'(BORDER);
    localparam logic [6:0]        COL_HI    = 7'(COLS - BORDER);
    localparam logic [5:0]        ROW_LO    = 6'(BORDER);
    localparam logic [5:0]        ROW_HI    = 6'(ROWS - BORDER);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(COLS * ROWS - 1);
    localparam logic [9:0]        PIX_X_LIM = 10'(COLS << CELL_SHIFT);
    localparam logic [9:0]        PIX_Y_LIM = 10'(ROWS << CELL_SHIFT);

    state_t state_q, state_d;

    logic [ADDR_W-1:0] sweep_addr_q, sweep_addr_d;
    logic [6:0]        sweep_col_q, sweep_col_d;
    logic [5:0]        sweep_row_q, sweep_row_d;

    logic              player_q;
    logic [ADDR_W-1:0] cur_addr_q;
    logic              cur_ok_q;
    logic [ADDR_W-1:0] nxt_addr_q;
    logic              nxt_oor_q;
    cell_t             code_q;
    logic              clear_pend_q, clear_pend_d;
    logic              pix_ok_q;

    logic              mv_accept;
    logic              sweep_wall;
    logic              pix_in_range;
    logic [ADDR_W-1:0] a_addr, b_addr;
    logic              a_we;
    cell_t             a_wdata, a_rdata, b_rdata;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_CLEAR;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_CLEAR: begin
                if (!clear_req && sweep_addr_q == LAST_ADDR) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (clear_req) begin
                    state_d = ST_CLEAR;
                end else if (mv_valid) begin
                    state_d = ST_READ;
                end
            end
            ST_READ:  state_d = ST_WRITE;
            ST_WRITE: state_d = ST_RESP;
            ST_RESP:  state_d = (clear_pend_q || clear_req) ? ST_CLEAR : ST_IDLE;
            default:  state_d = ST_CLEAR;
        endcase
    end

    // ---------------- FSM: outputs and port A control ----------------
    always_comb begin
        mv_ready   = 1'b0;
        res_valid  = 1'b0;
        clear_busy = 1'b0;
        a_addr     = '0;
        a_we       = 1'b0;
        a_wdata    = CELL_EMPTY;
        case (state_q)
            ST_CLEAR: begin
                clear_busy = 1'b1;
                a_addr     = sweep_addr_q;
                a_we       = 1'b1;
                a_wdata    = sweep_wall ? CELL_WALL : CELL_EMPTY;
            end
            ST_IDLE: begin
                mv_ready = 1'b1;
            end
            ST_READ: begin
                a_addr = nxt_addr_q;
            end
            ST_WRITE: begin
                // departed cells outside the grid are never written
                a_addr  = cur_addr_q;
                a_we    = cur_ok_q;
                a_wdata = player_q ? CELL_P2 : CELL_P1;
            end
            ST_RESP: begin
                res_valid = 1'b1;
            end
            default: ;
        endcase
    end

    assign sweep_wall = (sweep_row_q < ROW_LO) || (sweep_row_q >= ROW_HI) ||
                        (sweep_col_q < COL_LO) || (sweep_col_q >= COL_HI);

    // Sweep position; a clear request mid-sweep restarts from cell 0
    always_comb begin
        sweep_addr_d = '0;
        sweep_col_d  = '0;
        sweep_row_d  = '0;
        if (state_q == ST_CLEAR && !clear_req && sweep_addr_q != LAST_ADDR) begin
            sweep_addr_d = sweep_addr_q + 1'b1;
            if (sweep_col_q == COL_LIM - 7'd1) begin
                sweep_col_d = '0;
                sweep_row_d = sweep_row_q + 1'b1;
            end else begin
                sweep_col_d = sweep_col_q + 1'b1;
                sweep_row_d = sweep_row_q;
            end
        end
    end

    // Clear requests arriving mid-move are remembered until the move completes
    always_comb begin
        clear_pend_d = clear_pend_q;
        if (state_q == ST_RESP) begin
            clear_pend_d = 1'b0;
        end else if (state_q == ST_READ || state_q == ST_WRITE) begin
            clear_pend_d = clear_pend_q | clear_req;
        end
    end

    assign mv_accept = (state_q == ST_IDLE) && !clear_req && mv_valid;

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            sweep_addr_q <= '0;
            sweep_col_q  <= '0;
            sweep_row_q  <= '0;
            player_q     <= 1'b0;
            cur_addr_q   <= '0;
            cur_ok_q     <= 1'b0;
            nxt_addr_q   <= '0;
            nxt_oor_q    <= 1'b0;
            code_q       <= CELL_EMPTY;
            clear_pend_q <= 1'b0;
            pix_ok_q     <= 1'b0;
        end else begin
            sweep_addr_q <= sweep_addr_d;
            sweep_col_q  <= sweep_col_d;
            sweep_row_q  <= sweep_row_d;
            clear_pend_q <= clear_pend_d;
            pix_ok_q     <= pix_in_range;
            if (mv_accept) begin
                player_q   <= mv_player;
                cur_addr_q <= cell_addr(mv_cur_row, mv_cur_col);
                cur_ok_q   <= (mv_cur_col < COL_LIM) && (mv_cur_row < ROW_LIM);
                nxt_addr_q <= cell_addr(mv_nxt_row, mv_nxt_col);
                nxt_oor_q  <= (mv_nxt_col >= COL_LIM) || (mv_nxt_row >= ROW_LIM);
            end
            if (state_q == ST_WRITE) begin
                code_q <= nxt_oor_q ? CELL_WALL : a_rdata;
            end
        end
    end

    assign res_hit  = (code_q != CELL_EMPTY);
    assign res_code = code_q;

    // ---------------- Pixel lookup ----------------
    assign pix_in_range = (next_x < PIX_X_LIM) && (next_y < PIX_Y_LIM);
    assign b_addr       = pix_in_range ?
                          cell_addr(next_y[CELL_SHIFT +: 6], next_x[CELL_SHIFT +: 7]) : '0;

    assign pix_cell = (pix_ok_q && state_q != ST_CLEAR) ? b_rdata : CELL_EMPTY;

    grade_ram #(
        .DEPTH (NUM_CELLS),
        .AW    (ADDR_W),
        .DW    (2)
    ) u_ram (
        .clk     (CLOCK_50),
        .a_addr  (a_addr),
        .a_we    (a_we),
        .a_wdata (a_wdata),
        .a_rdata (a_rdata),
        .b_addr  (b_addr),
        .b_rdata (b_rdata)
    );

endmodule

// File: tb/tb_grade_arena.sv
// Self-checking bench for grade_arena: directed steps plus random moves,
// checked against a plain array model of the 80x60 arena.
module tb_grade_arena;

    logic       CLOCK_50 = 1'b0;
    logic       reset_n;
    logic       clear_req;
    logic       clear_busy;
    logic       mv_valid;
    logic       mv_ready;
    logic       mv_player;
    logic [6:0] mv_cur_col;
    logic [5:0] mv_cur_row;
    logic [6:0] mv_nxt_col;
    logic [5:0] mv_nxt_row;
    logic       res_valid;
    logic       res_hit;
    logic [1:0] res_code;
    logic [9:0] next_x;
    logic [9:0] next_y;
    logic [1:0] pix_cell;

    always #5 CLOCK_50 = ~CLOCK_50;

    grade_arena dut (
        .CLOCK_50   (CLOCK_50),
        .reset_n    (reset_n),
        .clear_req  (clear_req),
        .clear_busy (clear_busy),
        .mv_valid   (mv_valid),
        .mv_ready   (mv_ready),
        .mv_player  (mv_player),
        .mv_cur_col (mv_cur_col),
        .mv_cur_row (mv_cur_row),
        .mv_nxt_col (mv_nxt_col),
        .mv_nxt_row (mv_nxt_row),
        .res_valid  (res_valid),
        .res_hit    (res_hit),
        .res_code   (res_code),
        .next_x     (next_x),
        .next_y     (next_y),
        .pix_cell   (pix_cell)
    );

    int compared   = 0;
    int mismatched = 0;
    int grid [4800];
    int last_code  = 0;

    task automatic step();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic chk(input string tag, input int observed, input int expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Arena after a clear: 2-cell wall ring, empty inside
    task automatic model_clear();
        for (int r = 0; r < 60; r++) begin
            for (int c = 0; c < 80; c++) begin
                grid[r * 80 + c] = (r < 2 || r >= 58 || c < 2 || c >= 78) ? 3 : 0;
            end
        end
    endtask

    function automatic int pix_model(input int x, input int y);
        if (x >= 640 || y >= 480) return 0;
        return grid[(y / 8) * 80 + (x / 8)];
    endfunction

    task automatic pix(input int x, input int y, input string tag);
        next_x = 10'(x);
        next_y = 10'(y);
        step();
        chk(tag, int'(pix_cell), pix_model(x, y));
        $display("pix   %-10s x=%0d y=%0d cell=%0d", tag, x, y, pix_cell);
    endtask

    // Counts busy cycles from a point where the sweep sits at cell 0;
    // optionally pulses clear_req once after restart_at cycles.
    task automatic sweep_len(input int restart_at, output int n);
        n = 0;
        next_x = 10'd0;
        next_y = 10'd0;
        while (clear_busy && n < 6000) begin
            if (n == restart_at) clear_req = 1'b1;
            step();
            clear_req = 1'b0;
            n++;
            if (n == 50) chk("busy_pix", int'(pix_cell), 0);
        end
    endtask

    task automatic do_move(input int pl, input int cc, input int cr, input int nc,
                           input int nr, input bit hold, input bit clr_in_read,
                           input string tag);
        int exp_code;
        int waited;
        waited = 0;
        while (!mv_ready && waited < 20) begin
            step();
            waited++;
        end
        chk({tag, "_rdy"}, int'(mv_ready), 1);
        exp_code = (nc >= 80 || nr >= 60) ? 3 : grid[nr * 80 + nc];
        mv_valid   = 1'b1;
        mv_player  = pl[0];
        mv_cur_col = 7'(cc);
        mv_cur_row = 6'(cr);
        mv_nxt_col = 7'(nc);
        mv_nxt_row = 6'(nr);
        step();
        if (!hold) mv_valid = 1'b0;
        if (clr_in_read) clear_req = 1'b1;
        chk({tag, "_v1"}, int'(res_valid), 0);
        chk({tag, "_hold"}, int'(res_code), last_code);
        chk({tag, "_nrdy"}, int'(mv_ready), 0);
        step();
        clear_req = 1'b0;
        chk({tag, "_v2"}, int'(res_valid), 0);
        step();
        mv_valid = 1'b0;
        chk({tag, "_v3"}, int'(res_valid), 1);
        chk({tag, "_hit"}, int'(res_hit), (exp_code != 0) ? 1 : 0);
        chk({tag, "_code"}, int'(res_code), exp_code);
        $display("move  %-10s p%0d cur(%0d,%0d) nxt(%0d,%0d) hit=%0d code=%0d exp=%0d",
                 tag, pl + 1, cc, cr, nc, nr, res_hit, res_code, exp_code);
        if (cc < 80 && cr < 60) grid[cr * 80 + cc] = pl + 1;
        last_code = exp_code;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int pl, cc, cr, nc, nr, x, y;

        reset_n    = 1'b0;
        clear_req  = 1'b0;
        mv_valid   = 1'b0;
        mv_player  = 1'b0;
        mv_cur_col = '0;
        mv_cur_row = '0;
        mv_nxt_col = '0;
        mv_nxt_row = '0;
        next_x     = '0;
        next_y     = '0;

        // Test 1: reset and power-up sweep
        repeat (5) step();
        chk("rst_ready", int'(mv_ready), 0);
        chk("rst_valid", int'(res_valid), 0);
        chk("rst_hit", int'(res_hit), 0);
        chk("rst_code", int'(res_code), 0);
        chk("rst_pix", int'(pix_cell), 0);
        chk("rst_busy", int'(clear_busy), 1);
        reset_n = 1'b1;
        model_clear();
        last_code = 0;
        sweep_len(-1, n);
        chk("sweep1_len", n, 4800);
        $display("sweep initial cycles=%0d", n);
        pix(0, 0, "p00");
        pix(16, 16, "p16");
        pix(623, 463, "p623");
        pix(632, 472, "p632");
        pix(639, 479, "pcorner");
        pix(640, 0, "px_oor");
        pix(0, 480, "py_oor");

        // Tests 2-3: directed moves
        do_move(0, 27, 30, 28, 30, 1'b0, 1'b0, "t2");
        pix(216, 240, "t2_trail");
        do_move(0, 28, 30, 1, 30, 1'b0, 1'b0, "t3_wall");
        do_move(1, 26, 30, 27, 30, 1'b0, 1'b0, "t3_p1hit");
        pix(208, 247, "t3_trail");

        // Test 4: out-of-range destinations, held mv_valid
        do_move(1, 26, 31, 80, 31, 1'b1, 1'b0, "t4_col80");
        step();
        chk("t4_idle_rdy", int'(mv_ready), 1);
        step();
        chk("t4_no_2nd", int'(mv_ready), 1);
        chk("t4_no_2nd_v", int'(res_valid), 0);
        do_move(0, 40, 40, 40, 60, 1'b0, 1'b0, "t4_row60");
        do_move(0, 41, 40, 127, 63, 1'b0, 1'b0, "t4_max");
        do_move(0, 10, 10, 10, 10, 1'b0, 1'b0, "eq_first");
        do_move(1, 10, 10, 10, 10, 1'b0, 1'b0, "eq_again");

        // Random moves with pixel spot checks
        for (int i = 0; i < 40; i++) begin
            pl = int'($urandom_range(0, 1));
            cc = int'($urandom_range(0, 79));
            cr = int'($urandom_range(0, 59));
            nc = ($urandom_range(0, 7) == 0) ? int'($urandom_range(80, 127))
                                              : int'($urandom_range(0, 79));
            nr = ($urandom_range(0, 7) == 0) ? int'($urandom_range(60, 63))
                                              : int'($urandom_range(0, 59));
            if ($urandom_range(0, 3) == 0) begin
                nc = (cc < 79) ? cc + 1 : cc - 1;
                nr = cr;
            end
            do_move(pl, cc, cr, nc, nr, 1'b0, 1'b0, "rnd");
            pix(cc * 8 + int'($urandom_range(0, 7)), cr * 8 + int'($urandom_range(0, 7)),
                "rnd_trail");
            x = int'($urandom_range(0, 700));
            y = int'($urandom_range(0, 520));
            pix(x, y, "rnd_any");
        end

        // Test 5: clear request during READ is deferred until after the result
        do_move(0, 20, 20, 0, 0, 1'b0, 1'b1, "t5");
        step();
        chk("t5_busy", int'(clear_busy), 1);
        model_clear();
        sweep_len(-1, n);
        chk("t5_len", n, 4800);
        $display("sweep deferred cycles=%0d", n);
        chk("t5_hit_held", int'(res_hit), 1);
        chk("t5_code_held", int'(res_code), last_code);
        pix(216, 240, "t5_cleared");
        pix(8, 8, "t5_wall");

        // Test 6: asynchronous reset in the middle of a sweep
        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        chk("t6_busy", int'(clear_busy), 1);
        repeat (2000) step();
        #2;
        reset_n = 1'b0;
        #1;
        chk("t6_ready", int'(mv_ready), 0);
        chk("t6_valid", int'(res_valid), 0);
        chk("t6_hit", int'(res_hit), 0);
        chk("t6_code", int'(res_code), 0);
        chk("t6_pix", int'(pix_cell), 0);
        chk("t6_busy_rst", int'(clear_busy), 1);
        repeat (5) step();
        reset_n = 1'b1;
        last_code = 0;
        model_clear();
        sweep_len(-1, n);
        chk("t6_len", n, 4800);
        $display("sweep after reset cycles=%0d", n);
        do_move(1, 50, 50, 51, 50, 1'b0, 1'b0, "t6_move");
        pix(400, 400, "t6_trail");

        // Test 7: clear request during a sweep restarts it from cell 0
        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        model_clear();
        sweep_len(100, n);
        chk("t7_len", n, 4901);
        $display("sweep restarted cycles=%0d", n);
        pix(400, 400, "t7_cleared");
        pix(632, 0, "t7_wall");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
